// File: rtl/cos_pkg.sv
// rtl/cos_pkg.sv - shared constants, FSM encoding and job word layout for the cosine job sequencer
package cos_pkg;

  localparam int WIDTH_DEFAULT = 16;
  localparam int FRAC_BITS     = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } seq_state_t;

  // A queued job is the word {y, x}: x in the low WIDTH bits, y directly above it.
  localparam int JOB_X_LSB = 0;

endpackage

// File: rtl/cos_job_fifo.sv
// rtl/cos_job_fifo.sv - synchronous job FIFO with full/empty/count, power-of-2 depth
module cos_job_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/cos_job_sequencer.sv
// rtl/cos_job_sequencer.sv - queues (x, y) jobs and drives the cosine accelerator start/ready handshake
module cos_job_sequencer
  import cos_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEFAULT,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_x,
  input  logic [WIDTH-1:0]         in_y,
  output logic                     acc_start,
  output logic [WIDTH-1:0]         acc_x,
  output logic [WIDTH-1:0]         acc_y,
  input  logic                     acc_ready,
  input  logic [WIDTH-1:0]         acc_cosx,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_cos,
  output logic                     out_timeout,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int CW        = $clog2(TIMEOUT + 1);
  localparam int JW        = 2 * WIDTH;
  localparam int JOB_Y_LSB = JOB_X_LSB + WIDTH;

  seq_state_t    state, state_next;
  logic [JW-1:0] head;
  logic          full, empty, push, pop;
  logic          job_avail, done_ok, done_tmo, tmo_hit;
  logic [CW-1:0] tmo_cnt;

  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign busy     = (state != IDLE);
  assign tmo_hit  = (tmo_cnt == CW'(TIMEOUT - 1));

  cos_job_fifo #(
    .WIDTH (JW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata ({in_y, in_x}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    done_ok    = 1'b0;
    done_tmo   = 1'b0;
    case (state)
      IDLE: begin
        if (job_avail && !empty && acc_ready && !out_valid) begin
          state_next = START;
          pop        = 1'b1;
        end
      end
      START: state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tmo_hit) begin
          done_tmo   = 1'b1;
          state_next = IDLE;
        end else if (!acc_ready) begin
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (tmo_hit) begin
          done_tmo   = 1'b1;
          state_next = IDLE;
        end else if (acc_ready) begin
          done_ok    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // job_avail lags the FIFO by a cycle so a fresh push lands in storage before launch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      acc_start   <= 1'b0;
      acc_x       <= '0;
      acc_y       <= '0;
      tmo_cnt     <= '0;
      job_avail   <= 1'b0;
      out_valid   <= 1'b0;
      out_cos     <= '0;
      out_timeout <= 1'b0;
    end else begin
      state     <= state_next;
      acc_start <= (state_next == START);
      job_avail <= !empty;
      if (pop) begin
        acc_x <= head[JOB_X_LSB +: WIDTH];
        acc_y <= head[JOB_Y_LSB +: WIDTH];
      end
      if (state == START) begin
        tmo_cnt <= '0;
      end else if (state == WAIT_BUSY || state == WAIT_DONE) begin
        tmo_cnt <= tmo_cnt + CW'(1);
      end
      if (done_tmo) begin
        out_valid   <= 1'b1;
        out_cos     <= '0;
        out_timeout <= 1'b1;
      end else if (done_ok) begin
        out_valid   <= 1'b1;
        out_cos     <= acc_cosx;
        out_timeout <= 1'b0;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cos_job_sequencer.sv
// tb/tb_cos_job_sequencer.sv - self-checking bench with accelerator stub and queue-based result model
module tb_cos_job_sequencer;

  localparam int WIDTH   = 16;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 255;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_x = '0;
  logic [WIDTH-1:0] in_y = '0;
  logic             acc_start;
  logic [WIDTH-1:0] acc_x, acc_y;
  logic             acc_ready = 1'b1;
  logic [WIDTH-1:0] acc_cosx = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_cos;
  logic             out_timeout;
  logic             busy;
  logic [2:0]       count;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [WIDTH-1:0] exp_q[$];

  int stub_lat = 10;
  bit drop_en = 1'b1;
  bit hold_rise = 1'b0;
  bit hold_low = 1'b0;
  int cos_sel = 0;
  int phase = 0;
  int k = 0;
  int starts = 0;
  int raise_cyc = -1;
  logic [WIDTH-1:0] st_x = '0;

  cos_job_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .acc_start(acc_start), .acc_x(acc_x), .acc_y(acc_y),
    .acc_ready(acc_ready), .acc_cosx(acc_cosx),
    .out_valid(out_valid), .out_ready(out_ready), .out_cos(out_cos),
    .out_timeout(out_timeout), .busy(busy), .count(count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [WIDTH-1:0] cos_of(input logic [WIDTH-1:0] x, input int sel);
    case (sel)
      0:       return 16'h0080;
      1:       return x;
      default: return x ^ 16'hA5C3;
    endcase
  endfunction

  // Accelerator stub: drops ready one cycle after start, raises it stub_lat cycles later.
  always @(negedge clock) begin
    if (reset) begin
      acc_ready = 1'b1;
      phase = 0;
    end else if (hold_low) begin
      acc_ready = 1'b0;
    end else if (acc_start) begin
      st_x = acc_x;
      starts++;
      phase = 1;
    end else if (phase == 1) begin
      if (drop_en) begin
        acc_ready = 1'b0;
        phase = 2;
        k = 0;
      end else begin
        phase = 0;
      end
    end else if (phase == 2) begin
      k++;
      if (k >= stub_lat && !hold_rise) begin
        acc_ready = 1'b1;
        acc_cosx = cos_of(st_x, cos_sel);
        raise_cyc = cyc;
        phase = 0;
      end
    end else if (!acc_ready) begin
      acc_ready = 1'b1;
    end
  end

  task automatic push_job(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, output bit accepted);
    in_valid = 1'b1;
    in_x = x;
    in_y = y;
    accepted = in_ready;
    @(negedge clock);
    in_valid = 1'b0;
    if (accepted) exp_q.push_back(x);
  endtask

  task automatic wait_start(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      if (acc_start) begin
        at = cyc;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic get_result(input int bound, output bit got, output logic [WIDTH-1:0] c,
                            output logic tm, output int at);
    got = 1'b0;
    c = '0;
    tm = 1'b0;
    at = -1;
    for (int i = 0; i < bound; i++) begin
      if (out_valid) begin
        got = 1'b1;
        c = out_cos;
        tm = out_timeout;
        at = cyc;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    n_cmp++; if (acc_start !== 1'b0) begin n_err++; $display("FAIL reset_acc_start: got %b want 0", acc_start); end
    n_cmp++; if (acc_x !== 16'h0 || acc_y !== 16'h0) begin n_err++; $display("FAIL reset_acc_xy: got %h/%h want 0/0", acc_x, acc_y); end
    n_cmp++; if (out_valid !== 1'b0 || out_timeout !== 1'b0) begin n_err++; $display("FAIL reset_out_flags: got %b/%b want 0/0", out_valid, out_timeout); end
    n_cmp++; if (out_cos !== 16'h0) begin n_err++; $display("FAIL reset_out_cos: got %h want 0", out_cos); end
    n_cmp++; if (busy !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin n_err++; $display("FAIL reset_fifo: got busy=%b count=%0d in_ready=%b want 0/0/1", busy, count, in_ready); end
    #2 reset = 1'b0;
    @(negedge clock);
    n_cmp++; if (busy !== 1'b0 || acc_start !== 1'b0) begin n_err++; $display("FAIL reset_release_idle: got busy=%b start=%b want 0/0", busy, acc_start); end
  endtask

  task automatic test_single();
    bit acc, got;
    int t, at, rv;
    logic [WIDTH-1:0] c;
    logic tm;
    exp_q.delete();
    cos_sel = 0; stub_lat = 10; drop_en = 1'b1; hold_rise = 1'b0;
    push_job(16'h010C, 16'h0066, acc);
    t = cyc;
    n_cmp++; if (acc !== 1'b1) begin n_err++; $display("FAIL single_accept: got %b want 1", acc); end
    wait_start(20, at);
    n_cmp++; if (at != t + 2) begin n_err++; $display("FAIL single_start_latency: got edge %0d want %0d", at, t + 2); end
    n_cmp++; if (acc_x !== 16'h010C) begin n_err++; $display("FAIL single_acc_x: got %h want 010c", acc_x); end
    n_cmp++; if (acc_y !== 16'h0066) begin n_err++; $display("FAIL single_acc_y: got %h want 0066", acc_y); end
    @(negedge clock);
    n_cmp++; if (acc_start !== 1'b0) begin n_err++; $display("FAIL single_start_width: got %b want 0", acc_start); end
    get_result(100, got, c, tm, rv);
    n_cmp++; if (!got) begin n_err++; $display("FAIL single_result_seen: got none want out_valid"); end
    n_cmp++; if (rv != raise_cyc + 1) begin n_err++; $display("FAIL single_valid_timing: got edge %0d want %0d", rv, raise_cyc + 1); end
    n_cmp++; if (c !== 16'h0080 || tm !== 1'b0) begin n_err++; $display("FAIL single_result: got %h tmo=%b want 0080 tmo=0", c, tm); end
    consume();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_consume: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    bit acc, got;
    int rv;
    logic [WIDTH-1:0] c, e;
    logic tm;
    exp_q.delete();
    cos_sel = 1; stub_lat = 3;
    hold_low = 1'b1;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      push_job(16'h0100 + 16'(i), 16'h000A, acc);
      n_cmp++; if (acc !== 1'b1) begin n_err++; $display("FAIL b2b_accept_%0d: got %b want 1", i, acc); end
    end
    n_cmp++; if (in_ready !== 1'b0 || count !== 3'd4) begin n_err++; $display("FAIL b2b_full: got in_ready=%b count=%0d want 0/4", in_ready, count); end
    push_job(16'h0104, 16'h000A, acc);
    n_cmp++; if (acc !== 1'b0 || count !== 3'd4) begin n_err++; $display("FAIL b2b_reject_5th: got acc=%b count=%0d want 0/4", acc, count); end
    hold_low = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (in_ready) got = 1'b1;
      else @(negedge clock);
    end
    n_cmp++; if (!got || count !== 3'd3) begin n_err++; $display("FAIL b2b_first_pop: got ready=%b count=%0d want 1/3", got, count); end
    push_job(16'h0104, 16'h000A, acc);
    n_cmp++; if (acc !== 1'b1) begin n_err++; $display("FAIL b2b_accept_5th: got %b want 1", acc); end
    for (int i = 0; i < 5; i++) begin
      get_result(200, got, c, tm, rv);
      e = (exp_q.size() > 0) ? cos_of(exp_q.pop_front(), cos_sel) : 16'hxxxx;
      n_cmp++; if (!got || c !== e || tm !== 1'b0) begin n_err++; $display("FAIL b2b_result_%0d: got valid=%b cos=%h tmo=%b want 1/%h/0", i, got, c, tm, e); end
      consume();
    end
  endtask

  task automatic test_backpressure();
    bit acc, got, stable;
    int rv, s0, ce, at;
    logic [WIDTH-1:0] c, e;
    logic tm;
    exp_q.delete();
    cos_sel = 1; stub_lat = 4;
    push_job(16'($urandom), 16'($urandom), acc);
    push_job(16'($urandom), 16'($urandom), acc);
    get_result(100, got, c, tm, rv);
    e = cos_of(exp_q.pop_front(), cos_sel);
    n_cmp++; if (!got || c !== e) begin n_err++; $display("FAIL bp_first: got valid=%b cos=%h want 1/%h", got, c, e); end
    s0 = starts;
    stable = 1'b1;
    repeat (20) begin
      @(negedge clock);
      if (out_valid !== 1'b1 || out_cos !== c || acc_start !== 1'b0) stable = 1'b0;
    end
    n_cmp++; if (!stable) begin n_err++; $display("FAIL bp_hold_stable: got unstable output want held"); end
    n_cmp++; if (starts != s0) begin n_err++; $display("FAIL bp_no_launch: got %0d starts want %0d", starts, s0); end
    out_ready = 1'b1;
    @(negedge clock);
    ce = cyc;
    out_ready = 1'b0;
    wait_start(10, at);
    n_cmp++; if (at != ce + 1) begin n_err++; $display("FAIL bp_relaunch: got edge %0d want %0d", at, ce + 1); end
    get_result(100, got, c, tm, rv);
    e = cos_of(exp_q.pop_front(), cos_sel);
    n_cmp++; if (!got || c !== e || tm !== 1'b0) begin n_err++; $display("FAIL bp_second: got valid=%b cos=%h tmo=%b want 1/%h/0", got, c, tm, e); end
    consume();
  endtask

  task automatic test_timeout(input bit no_rise);
    bit acc, got, quiet;
    int at, rv, s0;
    logic [WIDTH-1:0] c;
    logic tm;
    exp_q.delete();
    drop_en = no_rise;
    hold_rise = no_rise;
    push_job(16'($urandom), 16'h0003, acc);
    wait_start(20, at);
    get_result(TIMEOUT + 50, got, c, tm, rv);
    n_cmp++; if (!got || rv != at + TIMEOUT + 1) begin n_err++; $display("FAIL tmo%0d_latency: got edge %0d want %0d", no_rise, rv, at + TIMEOUT + 1); end
    n_cmp++; if (c !== 16'h0 || tm !== 1'b1) begin n_err++; $display("FAIL tmo%0d_result: got cos=%h tmo=%b want 0000/1", no_rise, c, tm); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL tmo%0d_idle: got busy=%b want 0", no_rise, busy); end
    consume();
    drop_en = 1'b1;
    if (no_rise) begin
      s0 = starts;
      hold_rise = 1'b0;
      quiet = 1'b1;
      repeat (20) begin
        @(negedge clock);
        if (out_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
      end
      n_cmp++; if (!quiet || starts != s0) begin n_err++; $display("FAIL tmo_late_rise: got quiet=%b starts=%0d want 1/%0d", quiet, starts, s0); end
    end
  endtask

  task automatic test_random_stream();
    exp_q.delete();
    cos_sel = 2;
    fork
      begin
        bit acc;
        int tries;
        for (int i = 0; i < 12; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clock);
          tries = 0;
          do begin
            push_job(16'($urandom), 16'($urandom), acc);
            tries++;
          end while (!acc && tries < 500);
        end
      end
      begin
        bit got;
        int rv;
        logic [WIDTH-1:0] c, e;
        logic tm;
        for (int i = 0; i < 12; i++) begin
          stub_lat = $urandom_range(1, 12);
          get_result(600, got, c, tm, rv);
          e = (exp_q.size() > 0) ? cos_of(exp_q.pop_front(), cos_sel) : 16'hxxxx;
          n_cmp++; if (!got || c !== e || tm !== 1'b0) begin n_err++; $display("FAIL rand_result_%0d: got valid=%b cos=%h tmo=%b want 1/%h/0", i, got, c, tm, e); end
          if (!got) break;
          repeat ($urandom_range(0, 4)) @(negedge clock);
          consume();
        end
      end
    join
  endtask

  task automatic test_reset_mid_op();
    bit acc, got;
    int at, rv;
    logic [WIDTH-1:0] c, e;
    logic tm;
    exp_q.delete();
    cos_sel = 1; stub_lat = 40;
    for (int i = 0; i < 4; i++) push_job(16'($urandom), 16'($urandom), acc);
    wait_start(20, at);
    for (int i = 0; i < 10 && acc_ready; i++) @(negedge clock);
    repeat (2) @(negedge clock);
    n_cmp++; if (count !== 3'd3 || busy !== 1'b1) begin n_err++; $display("FAIL rst_pre: got count=%0d busy=%b want 3/1", count, busy); end
    reset = 1'b1;
    #1;
    n_cmp++; if (acc_start !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL rst_mid_fifo: got start=%b count=%0d want 0/0", acc_start, count); end
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_flags: got valid=%b in_ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy); end
    @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    exp_q.delete();
    stub_lat = 5;
    push_job(16'($urandom), 16'($urandom), acc);
    get_result(100, got, c, tm, rv);
    e = cos_of(exp_q.pop_front(), cos_sel);
    n_cmp++; if (!got || c !== e || tm !== 1'b0) begin n_err++; $display("FAIL rst_after_job: got valid=%b cos=%h tmo=%b want 1/%h/0", got, c, tm, e); end
    consume();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_random_stream();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion want finish within 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cos_job_sequencer.md
Name: cos_job_sequencer

Overview:
Requester-side controller for the iterative cosine accelerator's start/ready handshake. It buffers (x, y) jobs in a small FIFO and launches them one at a time with a single-cycle start pulse. It then tracks the accelerator's ready drop and rise, captures cosx, and presents results in order on a valid/ready output. It sits between the host/bus logic and the accelerator, so no host ever drives start directly.

Parameters:
WIDTH, 16, data width of x, y and cosx (Q8.8 fixed point)
DEPTH, 4, job FIFO depth; must be a power of 2
TIMEOUT, 255, maximum cycles spent in WAIT_BUSY plus WAIT_DONE before a job is aborted

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  job offered
in_ready  out  1  job FIFO not full
in_x  in  WIDTH  angle, Q8.8 (0x010C = pi/3)
in_y  in  WIDTH  accelerator precision/term-limit operand, passed through unchanged
acc_start  out  1  start pulse to accelerator
acc_x  out  WIDTH  x operand to accelerator
acc_y  out  WIDTH  y operand to accelerator
acc_ready  in  1  accelerator idle/done
acc_cosx  in  WIDTH  accelerator result
out_valid  out  1  result available
out_ready  in  1  result consumed
out_cos  out  WIDTH  captured cosx (0 on timeout)
out_timeout  out  1  result is an aborted job
busy  out  1  state != IDLE
count  out  clog2(DEPTH)+1  jobs queued in the FIFO

Behaviour:
- Reset (async): state IDLE, FIFO empty, count=0, acc_start=0, acc_x=acc_y=0, out_valid=0, out_cos=0, out_timeout=0, busy=0, in_ready=1.
- FIFO: push on in_valid&&in_ready. in_ready = !full, so no push when full, even if a pop occurs in the same cycle. Simultaneous push and pop when non-empty are both allowed, and count is unchanged. There is no empty bypass. Pointers wrap modulo DEPTH.
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
- IDLE -> START when FIFO non-empty && acc_ready && !out_valid. On that edge the FIFO head is popped into acc_x/acc_y.
- START: acc_start=1 for exactly one cycle, then unconditionally -> WAIT_BUSY. The timeout counter clears to 0.
- WAIT_BUSY: acc_ready==0 -> WAIT_DONE.
- WAIT_DONE: acc_ready==1 -> capture acc_cosx into out_cos, set out_valid=1 and out_timeout=0, then -> IDLE.
- Timeout: the counter increments every cycle in WAIT_BUSY and WAIT_DONE. When it reaches TIMEOUT in either state: out_cos=0, out_timeout=1, out_valid=1, then -> IDLE. Timeout takes priority over a same-cycle acc_ready transition.
- acc_x/acc_y are held stable from the pop until the next pop. acc_start is registered and is never asserted outside START.
- Output: out_valid is held with out_cos/out_timeout stable until out_valid&&out_ready, and clears on that edge. No new launch occurs while out_valid=1, so results are strictly in push order.
- Latency: a job pushed at edge t, with the FIFO empty, acc_ready=1 and out_valid=0, gives acc_start high in the cycle after edge t+2. out_valid rises on the edge after acc_ready returns high in WAIT_DONE.
- An acc_ready rise seen in IDLE, or while out_valid=1, is ignored.
- Reset mid-operation: everything returns to reset values immediately. The queued jobs and any in-flight result are discarded. The accelerator shares the reset net.

Decomposition:
- Package cos_pkg holds:
  - WIDTH_DEFAULT = 16 and FRAC_BITS = 8 (Q8.8).
  - The state encoding localparams IDLE=0, START=1, WAIT_BUSY=2, WAIT_DONE=3.
  - The job word layout {y, x} (2*WIDTH bits).
- One sub-module, cos_job_fifo: a synchronous FIFO with width 2*WIDTH and depth DEPTH, providing full, empty and count outputs.

Test Plan:
1. Push (x=0x010C, y=0x0066), with a stub that drops ready 1 cycle after start and raises it 10 cycles later with cosx=0x0080 -> exactly one acc_start cycle at t+2, acc_x=0x010C, acc_y=0x0066, then out_valid=1, out_cos=0x0080, out_timeout=0.
2. Push 5 jobs back-to-back (x=0x0100..0x0104, y=0x000A), with the stub returning cosx=x -> in_ready=0 after the 4th push until the first pop, 5th job accepted afterward, results 0x0100..0x0104 in order.
3. Hold out_ready=0 after the first result -> out_valid/out_cos stable, no second acc_start. Raising out_ready for one cycle -> next acc_start 2 cycles later.
4. Stub never drops acc_ready -> after TIMEOUT=255 cycles out_valid=1, out_timeout=1, out_cos=0, FSM back in IDLE.
5. Stub drops ready and never raises it -> timeout exactly as in scenario 4. A late acc_ready rise in IDLE produces no extra result.
6. Assert reset for one cycle during WAIT_DONE with 3 jobs queued -> acc_start=0, count=0, out_valid=0, in_ready=1, busy=0 immediately. A subsequent single job completes normally.
